shift_register_ctrl: RTL and testbench

Sequencing controller for the 8-bit universal shift register datapath. It accepts one command at a time over a valid/ready handshake: parallel load, shift right, shift left, or load-then-shift-right. It converts each command into a cycle-accurate stream of `mod` codes, load data and serial-in bits that drive the register. Completion is signalled with a one-cycle `done` pulse. It sits between the register-file/sequencer logic and the shift register instances, which share its `mod` and `clk`.

---
 rtl/shift_register_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_shift_register_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
// Purpose: sequences one load/shift command into per-cycle mod/ld_data/sin drive for the 8-bit universal shift register.
// Latency: outputs follow the FSM by one registered cycle; done lands accept+1 (zero shift), +2 (load), +N+1 (shift), +N+2 (load+shift).
// Backpressure: single command in flight; cmd_ready drops from accept until the cycle after the done/err pulse; abort frees it at once.
//
// Ports: clk/rst (async active-high); cmd_valid/cmd_ready handshake with cmd_op, cmd_cnt, cmd_data, cmd_sin;
//        abort (synchronous, ignored in IDLE); mod, ld_data, sin drive the register; busy, shifts_left, done, err report status.
// Optional feature: define SHIFT_REGISTER_CTRL_CNT_CHECK_EN to reject zero/oversize shift counts with an err pulse
// instead of clamping; without it err is constant 0.
module shift_register_ctrl #(
    parameter int MAX_SHIFT = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_sin,
    input  logic             abort,
    output logic [1:0]       mod,
    output logic [7:0]       ld_data,
    output logic             sin,
    output logic             busy,
    output logic [CNT_W-1:0] shifts_left,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFT);

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_SHR     = 2'b01;
    localparam logic [1:0] OP_SHL     = 2'b10;
    localparam logic [1:0] OP_LOADSHR = 2'b11;

    localparam logic [1:0] MOD_HOLD = 2'b00;
    localparam logic [1:0] MOD_SHR  = 2'b01;
    localparam logic [1:0] MOD_SHL  = 2'b10;
    localparam logic [1:0] MOD_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             err_flag_q, err_flag_d;
    logic [1:0]       mod_q, mod_d;
    logic [7:0]       ld_data_q, ld_data_d;
    logic             sin_q, sin_d;
    logic [CNT_W-1:0] shifts_left_q, shifts_left_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_clamped;
    logic             cnt_bad;

    // While a done/err pulse is still on the outputs the FSM is already back in
    // IDLE; holding cmd_ready low here keeps the pulse inside the busy window.
    assign cmd_ready = (state_q == S_IDLE) && !done_q && !err_q && !rst;
    assign busy      = (state_q != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign cnt_clamped = (cmd_cnt > MAX_CNT) ? MAX_CNT : cmd_cnt;

`ifdef SHIFT_REGISTER_CTRL_CNT_CHECK_EN
    assign cnt_bad = (cmd_op != OP_LOAD) && ((cmd_cnt == '0) || (cmd_cnt > MAX_CNT));
`else
    assign cnt_bad = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        err_flag_d    = err_flag_q;
        ld_data_d     = ld_data_q;
        sin_d         = sin_q;
        mod_d         = MOD_HOLD;
        shifts_left_d = '0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        // Registered outputs describe the state being left, so the register
        // sees each mode for exactly the cycle after the FSM visited it.
        case (state_q)
            S_LOAD:  mod_d = MOD_LOAD;
            S_SHIFT: begin
                mod_d         = (op_q == OP_SHL) ? MOD_SHL : MOD_SHR;
                shifts_left_d = cnt_q;
            end
            S_DONE: begin
                done_d = !err_flag_q;
                err_d  = err_flag_q;
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = cmd_op;
                    ld_data_d  = cmd_data;
                    sin_d      = cmd_sin;
                    cnt_d      = cnt_clamped;
                    err_flag_d = cnt_bad;
                    if (cnt_bad) begin
                        state_d = S_DONE;
                    end else if ((cmd_op == OP_LOAD) || (cmd_op == OP_LOADSHR)) begin
                        state_d = S_LOAD;
                    end else if (cnt_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_LOAD: begin
                if ((op_q == OP_LOADSHR) && (cnt_q != '0)) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                err_flag_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything once a command is running; in IDLE it is
        // ignored so a same-cycle accept still goes through.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            err_flag_d    = 1'b0;
            mod_d         = MOD_HOLD;
            shifts_left_d = '0;
            done_d        = 1'b0;
            err_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= OP_LOAD;
            err_flag_q    <= 1'b0;
            mod_q         <= MOD_HOLD;
            ld_data_q     <= '0;
            sin_q         <= 1'b0;
            shifts_left_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            err_flag_q    <= err_flag_d;
            mod_q         <= mod_d;
            ld_data_q     <= ld_data_d;
            sin_q         <= sin_d;
            shifts_left_q <= shifts_left_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign mod         = mod_q;
    assign ld_data     = ld_data_q;
    assign sin         = sin_q;
    assign shifts_left = shifts_left_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Purpose: randomized + directed bench for shift_register_ctrl against a per-command expected output trace.
// Latency: samples outputs 1 time unit after each rising clk edge.
// Backpressure: waits (bounded) on cmd_ready before each command.
module tb_shift_register_ctrl;
    localparam int MAX_SHIFT = 8;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [7:0]       cmd_data = 8'h00;
    logic             cmd_sin = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       mod;
    logic [7:0]       ld_data;
    logic             sin;
    logic             busy;
    logic [CNT_W-1:0] shifts_left;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    shift_register_ctrl #(.MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
        .abort(abort), .mod(mod), .ld_data(ld_data), .sin(sin), .busy(busy),
        .shifts_left(shifts_left), .done(done), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One entry per cycle after the accept edge: what the outputs must show.
    typedef struct packed {
        logic [1:0]       mod;
        logic [CNT_W-1:0] sl;
        logic             done;
        logic             err;
    } exp_t;

    exp_t seq[$];

    // Register instance model driven from the DUT outputs, plus its expected value.
    logic [7:0] sreg     = 8'h00;
    logic [7:0] sreg_exp = 8'h00;

    function automatic bit cnt_rejected(input logic [1:0] op, input int cnt);
`ifdef SHIFT_REGISTER_CTRL_CNT_CHECK_EN
        return (op != 2'b00) && ((cnt == 0) || (cnt > MAX_SHIFT));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff_count(input logic [1:0] op, input int cnt);
        if (op == 2'b00) return 0;
        return (cnt > MAX_SHIFT) ? MAX_SHIFT : cnt;
    endfunction

    task automatic build_seq(input logic [1:0] op, input int cnt);
        int n;
        seq.delete();
        if (cnt_rejected(op, cnt)) begin
            seq.push_back('{2'b00, '0, 1'b0, 1'b1});
            return;
        end
        n = eff_count(op, cnt);
        if (op == 2'b00 || op == 2'b11) seq.push_back('{2'b11, '0, 1'b0, 1'b0});
        for (int i = n; i >= 1; i--)
            seq.push_back('{(op == 2'b10) ? 2'b10 : 2'b01, CNT_W'(i), 1'b0, 1'b0});
        seq.push_back('{2'b00, '0, 1'b1, 1'b0});
    endtask

    // Expected register contents after a completed command, from the op semantics.
    function automatic logic [7:0] ref_reg(input logic [7:0] r, input logic [1:0] op, input int cnt,
                                           input logic [7:0] data, input logic s);
        logic [7:0] v;
        int n;
        v = r;
        if (cnt_rejected(op, cnt)) return v;
        n = eff_count(op, cnt);
        if (op == 2'b00 || op == 2'b11) v = data;
        for (int i = 0; i < n; i++) begin
            if (op == 2'b10) v = {v[6:0], s};
            else             v = {s, v[7:1]};
        end
        return v;
    endfunction

    task automatic reg_step();
        case (mod)
            2'b11:   sreg = ld_data;
            2'b01:   sreg = {sin, sreg[7:1]};
            2'b10:   sreg = {sreg[6:0], sin};
            default: ;
        endcase
    endtask

    task automatic tick();
        reg_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        ok = cmd_ready;
        if (!ok) chk_eq("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // abort_at: edge index after the accept at which abort is sampled (<=0: none).
    task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [7:0] data,
                           input logic s, input int abort_at, input bit abort_on_accept);
        int L, last;
        bit ok, aborted;
        exp_t e;
        build_seq(op, cnt);
        L = seq.size();
        aborted = (abort_at >= 1) && (abort_at <= L);
        last = aborted ? abort_at : L + 1;
        wait_ready(ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = CNT_W'(cnt); cmd_data = data; cmd_sin = s;
        abort = abort_on_accept;
        tick();
        cmd_valid = 1'b0; abort = 1'b0;
        cmd_op = 2'($urandom); cmd_cnt = CNT_W'($urandom); cmd_data = 8'($urandom); cmd_sin = 1'($urandom);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                abort = (k == abort_at);
                tick();
                abort = 1'b0;
            end
            e = '0;
            if (k >= 1 && k <= L && !(aborted && k >= abort_at)) e = seq[k-1];
            chk_eq("mod", 32'(mod), 32'(e.mod));
            chk_eq("shifts_left", 32'(shifts_left), 32'(e.sl));
            chk_eq("done", 32'(done), 32'(e.done));
            chk_eq("err", 32'(err), 32'(e.err));
            chk_eq("busy", 32'(busy), aborted && k >= abort_at ? 32'd0 : 32'(k < L));
            chk_eq("cmd_ready", 32'(cmd_ready), aborted ? 32'(k >= abort_at) : 32'(k > L));
            chk_eq("ld_data", 32'(ld_data), 32'(data));
            chk_eq("sin", 32'(sin), 32'(s));
        end
        if (aborted) begin
            sreg_exp = sreg;
        end else begin
            reg_step();
            sreg_exp = ref_reg(sreg_exp, op, cnt, data, s);
            chk_eq("reg_out", 32'(sreg), 32'(sreg_exp));
            sreg = sreg_exp;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset held with a pending command: nothing accepted, outputs at reset values.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd3; cmd_data = 8'h5A; cmd_sin = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk_eq("rst_mod", 32'(mod), 32'd0);
        chk_eq("rst_ld_data", 32'(ld_data), 32'd0);
        chk_eq("rst_sin", 32'(sin), 32'd0);
        chk_eq("rst_shifts_left", 32'(shifts_left), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_err", 32'(err), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        chk_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk_eq("post_rst_busy", 32'(busy), 32'd0);

        // Directed cases.
        run_cmd(2'b00, 0, 8'hA5, 1'b0, 0, 1'b0);
        run_cmd(2'b11, 8, 8'hA5, 1'b1, 0, 1'b0);
        chk_eq("reg_ff", 32'(sreg), 32'hFF);
        run_cmd(2'b10, 3, 8'h3C, 1'b0, 3, 1'b0);
        run_cmd(2'b01, 12, 8'h81, 1'b0, 0, 1'b0);
        run_cmd(2'b01, 0, 8'h42, 1'b1, 0, 1'b0);
        run_cmd(2'b11, 0, 8'h99, 1'b0, 0, 1'b0);
        run_cmd(2'b01, 5, 8'h17, 1'b1, 0, 1'b1);
        run_cmd(2'b11, 4, 8'hC3, 1'b0, 1, 1'b0);
        run_cmd(2'b00, 0, 8'hE7, 1'b0, 2, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int cnt, ab;
            op  = 2'($urandom);
            cnt = int'($urandom_range(0, 15));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            run_cmd(op, cnt, 8'($urandom), 1'($urandom), ab, 1'($urandom_range(0, 1)));
        end

        // Reset mid-command: mod must drop asynchronously.
        wait_ready(ok);
        if (ok) begin
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd5; cmd_data = 8'h11; cmd_sin = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(posedge clk); #1;
            chk_eq("mid_mod_before", 32'(mod), 32'd1);
            #2 rst = 1'b1;
            #1;
            chk_eq("mid_rst_mod", 32'(mod), 32'd0);
            chk_eq("mid_rst_busy", 32'(busy), 32'd0);
            chk_eq("mid_rst_shifts_left", 32'(shifts_left), 32'd0);
            chk_eq("mid_rst_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk_eq("mid_rst_release_ready", 32'(cmd_ready), 32'd1);
            sreg = 8'h00; sreg_exp = 8'h00;
        end
        run_cmd(2'b10, 2, 8'h0F, 1'b1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
